// File: rtl/spii_master.sv
// SPI mode-0 master: one byte per transfer, MSB first, sck half-period of DIV clk cycles.
// All outputs are registered; the next-state logic computes every register's next value.
module spii_master #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       start,
  input  logic [7:0] tdat,
  input  logic       din,
  output logic       ss,
  output logic       sck,
  output logic       dout,
  output logic       done,
  output logic [7:0] rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam logic [7:0] LAST = 8'(DIV - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] bitc, bitc_nx;
  logic [7:0] tx, tx_nx;
  logic [7:0] rx, rx_nx;
  logic [7:0] rdata_nx;
  logic       ss_nx, sck_nx, dout_nx, done_nx;
  logic       end_ph;

  assign end_ph = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= IDLE;
      cnt   <= '0;
      bitc  <= '0;
      tx    <= '0;
      rx    <= '0;
      rdata <= '0;
      ss    <= 1'b1;
      sck   <= 1'b0;
      dout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bitc  <= bitc_nx;
      tx    <= tx_nx;
      rx    <= rx_nx;
      rdata <= rdata_nx;
      ss    <= ss_nx;
      sck   <= sck_nx;
      dout  <= dout_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 8'd1;
    bitc_nx  = bitc;
    tx_nx    = tx;
    rx_nx    = rx;
    rdata_nx = rdata;
    ss_nx    = ss;
    sck_nx   = sck;
    dout_nx  = dout;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx  = '0;
        bitc_nx = '0;
        if (start) begin
          state_nx = SETUP;
          tx_nx    = tdat;
          ss_nx    = 1'b0;
          dout_nx  = tdat[7];
        end
      end
      SETUP: begin
        if (end_ph) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          sck_nx   = 1'b1;
          rx_nx    = {rx[6:0], din};
        end
      end
      HIGH: begin
        if (end_ph) begin
          state_nx = LOW;
          cnt_nx   = '0;
          sck_nx   = 1'b0;
          // After the last bit, dout holds bit 0 through the trailing LOW phase
          if (bitc != 3'd7) begin
            tx_nx   = {tx[6:0], 1'b0};
            dout_nx = tx[6];
          end
        end
      end
      LOW: begin
        if (end_ph) begin
          cnt_nx = '0;
          if (bitc == 3'd7) begin
            state_nx = IDLE;
            ss_nx    = 1'b1;
            dout_nx  = 1'b0;
            done_nx  = 1'b1;
            rdata_nx = rx;
          end else begin
            state_nx = HIGH;
            bitc_nx  = bitc + 3'd1;
            sck_nx   = 1'b1;
            rx_nx    = {rx[6:0], din};
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spii_master.sv
// Directed bench for spii_master: a DIV=4 instance and a DIV=1 instance, observed through a selector.
module tb_spii_master;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tdat = 8'h00;
  logic       loop = 1'b1;
  logic       sel = 1'b0;

  logic       ss4, sck4, dout4, done4, din4, start4;
  logic [7:0] rdata4;
  logic       ss1, sck1, dout1, done1, din1, start1;
  logic [7:0] rdata1;

  logic       mss, msck, mdout, mdone;
  logic [7:0] mrdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign din4   = loop ? dout4 : 1'b1;
  assign din1   = loop ? dout1 : 1'b1;
  assign start4 = sel ? 1'b0 : start;
  assign start1 = sel ? start : 1'b0;

  assign mss    = sel ? ss1    : ss4;
  assign msck   = sel ? sck1   : sck4;
  assign mdout  = sel ? dout1  : dout4;
  assign mdone  = sel ? done1  : done4;
  assign mrdata = sel ? rdata1 : rdata4;

  spii_master #(.DIV(4)) u4 (
    .clk(clk), .rstb(rstb), .start(start4), .tdat(tdat), .din(din4),
    .ss(ss4), .sck(sck4), .dout(dout4), .done(done4), .rdata(rdata4)
  );

  spii_master #(.DIV(1)) u1 (
    .clk(clk), .rstb(rstb), .start(start1), .tdat(tdat), .din(din1),
    .ss(ss1), .sck(sck1), .dout(dout1), .done(done1), .rdata(rdata1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one transfer and watch it until done; optionally re-request start mid-transfer.
  task automatic xfer(input string tag, input logic [7:0] td, input logic lp,
                      input int re_at, input logic [7:0] re_dat,
                      output int cyc, output logic [7:0] bits, output int pulses,
                      output int hitot, output int himax, output logic ss_ok);
    int   run;
    logic prev;
    logic seen;
    loop   = lp;
    tdat   = td;
    start  = 1'b1;
    tick();
    chk({tag, "_accept_ss"}, 32'(mss), 32'd0);
    chk({tag, "_accept_dout"}, 32'(mdout), 32'(td[7]));
    start  = 1'b0;
    cyc    = 0;
    bits   = '0;
    pulses = 0;
    hitot  = 0;
    himax  = 0;
    run    = 0;
    ss_ok  = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (cyc == re_at) begin
        start = 1'b1;
        tdat  = re_dat;
      end else begin
        start = 1'b0;
      end
      prev = msck;
      tick();
      cyc++;
      if (msck && !prev) begin
        bits = {bits[6:0], mdout};
        pulses++;
        run = 0;
      end
      if (msck) begin
        run++;
        hitot++;
        if (run > himax) himax = run;
      end
      if (mdone) begin
        seen = 1'b1;
        break;
      end
      if (mss) ss_ok = 1'b0;
    end
    start = 1'b0;
    if (!seen) cyc = -1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (mdone) begin
        cyc = k;
        break;
      end
    end
  endtask

  int         cyc, pulses, hitot, himax, ndone;
  logic [7:0] bits;
  logic       ss_ok, ok;

  initial begin
    // Reset
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    chk("rst_ss", 32'(ss4), 32'd1);
    chk("rst_sck", 32'(sck4), 32'd0);
    chk("rst_dout", 32'(dout4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_rdata", 32'(rdata4), 32'h00);
    chk("rst_ss_div1", 32'(ss1), 32'd1);

    // Loopback A5
    xfer("a5", 8'hA5, 1'b1, -1, 8'h00, cyc, bits, pulses, hitot, himax, ss_ok);
    chk("a5_latency", 32'(cyc), 32'd68);
    chk("a5_dout_bits", 32'(bits), 32'hA5);
    chk("a5_rdata", 32'(mrdata), 32'hA5);
    chk("a5_ss_done", 32'(mss), 32'd1);
    chk("a5_ss_held", 32'(ss_ok), 32'd1);
    chk("a5_pulses", 32'(pulses), 32'd8);
    tick();
    chk("a5_done_1cyc", 32'(mdone), 32'd0);

    // din tied high, tdat 00
    xfer("ff", 8'h00, 1'b0, -1, 8'h00, cyc, bits, pulses, hitot, himax, ss_ok);
    chk("ff_latency", 32'(cyc), 32'd68);
    chk("ff_dout_bits", 32'(bits), 32'h00);
    chk("ff_rdata", 32'(mrdata), 32'hFF);
    chk("ff_pulses", 32'(pulses), 32'd8);
    chk("ff_high_total", 32'(hitot), 32'd32);
    chk("ff_high_max", 32'(himax), 32'd4);
    tick();

    // Second start mid-transfer with different tdat is ignored
    xfer("ign", 8'h5A, 1'b1, 20, 8'hC3, cyc, bits, pulses, hitot, himax, ss_ok);
    chk("ign_latency", 32'(cyc), 32'd68);
    chk("ign_rdata", 32'(mrdata), 32'h5A);
    chk("ign_dout_bits", 32'(bits), 32'h5A);
    ndone = 0;
    ok    = 1'b1;
    for (int k = 0; k < 90; k++) begin
      tick();
      if (mdone) ndone++;
      if (!mss) ok = 1'b0;
    end
    chk("ign_no_extra_done", 32'(ndone), 32'd0);
    chk("ign_ss_idle", 32'(ok), 32'd1);
    chk("ign_rdata_kept", 32'(mrdata), 32'h5A);

    // start held high: back-to-back 3C transfers
    loop  = 1'b1;
    tdat  = 8'h3C;
    start = 1'b1;
    tick();
    chk("b2b_accept_ss", 32'(mss), 32'd0);
    for (int t = 0; t < 2; t++) begin
      wait_done(cyc);
      chk("b2b_latency", 32'(cyc), 32'd68);
      chk("b2b_rdata", 32'(mrdata), 32'h3C);
      chk("b2b_ss_gap", 32'(mss), 32'd1);
      tick();
      chk("b2b_reaccept_ss", 32'(mss), 32'd0);
      chk("b2b_done_drop", 32'(mdone), 32'd0);
    end
    start = 1'b0;
    wait_done(cyc);
    chk("b2b_last_rdata", 32'(mrdata), 32'h3C);
    tick();

    // Abort with reset at cycle 30
    loop  = 1'b1;
    tdat  = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 30; k++) tick();
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    chk("abort_ss", 32'(mss), 32'd1);
    chk("abort_sck", 32'(msck), 32'd0);
    chk("abort_dout", 32'(mdout), 32'd0);
    chk("abort_rdata", 32'(mrdata), 32'h00);
    chk("abort_done", 32'(mdone), 32'd0);
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (mdone) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    rstb  = 1'b1;
    start = 1'b1;
    tick();
    rstb  = 1'b0;
    start = 1'b0;
    chk("rst_prio_ss", 32'(mss), 32'd1);
    xfer("post", 8'h66, 1'b1, -1, 8'h00, cyc, bits, pulses, hitot, himax, ss_ok);
    chk("post_latency", 32'(cyc), 32'd68);
    chk("post_rdata", 32'(mrdata), 32'h66);
    tick();

    // DIV=1 instance
    sel = 1'b1;
    tick();
    xfer("d1", 8'h81, 1'b1, -1, 8'h00, cyc, bits, pulses, hitot, himax, ss_ok);
    chk("d1_latency", 32'(cyc), 32'd17);
    chk("d1_rdata", 32'(mrdata), 32'h81);
    chk("d1_dout_bits", 32'(bits), 32'h81);
    chk("d1_pulses", 32'(pulses), 32'd8);
    chk("d1_high_max", 32'(himax), 32'd1);
    tick();
    chk("d1_done_1cyc", 32'(mdone), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
